// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Optional macro UART_TX_CTS_EN gates frame acceptance on the active-low cts_n input.
module uart_tx #(
   parameter int OVERSAMPLE = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_tick,
   input  logic [1:0]  data_bit_num_i,
   input  logic        parity_en_i,
   input  logic        parity_type_i,
   input  logic        stop_bit_num_i,
   input  logic        start_tx_i,
   input  logic [31:0] tx_data_i,
   output logic        tx_busy_o,
   output logic        tx_done_o,
   input  logic        cts_n,
   output logic        tx
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] tick_q, tick_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    last_q, last_d;
   logic          pen_q, pen_d;
   logic          par_q, par_d;
   logic          stop2_q, stop2_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          accept;
   logic          bit_end;
   logic [7:0]    data_mask;
   logic [7:0]    data_masked;
   logic          unused_data;

`ifdef UART_TX_CTS_EN
   assign accept = start_tx_i & ~cts_n;
`else
   logic unused_cts;
   assign unused_cts = cts_n;
   assign accept     = start_tx_i;
`endif

   assign unused_data = ^tx_data_i[31:8];

   // Only the N configured bits are kept, so both shifting and parity see zeros above them.
   assign data_mask   = 8'hFF >> (2'd3 - data_bit_num_i);
   assign data_masked = tx_data_i[7:0] & data_mask;
   assign bit_end     = tx_tick && (tick_q == TICK_LAST);

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      last_d  = last_q;
      pen_d   = pen_q;
      par_d   = par_q;
      stop2_d = stop2_q;
      if (tx_tick) tick_d = tick_q + 1'b1;

      case (state_q)
         IDLE: begin
            tick_d = '0;
            bit_d  = '0;
            if (accept) begin
               state_d = START;
               shift_d = data_masked;
               last_d  = 3'd4 + {1'b0, data_bit_num_i};
               pen_d   = parity_en_i;
               par_d   = (^data_masked) ^ parity_type_i;
               stop2_d = stop_bit_num_i;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               tick_d  = '0;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               tick_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == last_q) begin
                  bit_d   = '0;
                  state_d = pen_q ? PARITY : STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               tick_d  = '0;
               bit_d   = '0;
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               tick_d = '0;
               if (stop2_q && (bit_q == 3'd0)) begin
                  bit_d = 3'd1;
               end else begin
                  bit_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next state so tx never sees a combinational input path.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = par_d;
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_q != IDLE) && (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         last_q  <= '0;
         pen_q   <= 1'b0;
         par_q   <= 1'b0;
         stop2_q <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         last_q  <= last_d;
         pen_q   <= pen_d;
         par_q   <= par_d;
         stop2_q <= stop2_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx        = tx_q;
   assign tx_busy_o = busy_q;
   assign tx_done_o = done_q;

endmodule
